// File: rtl/xinput_port.sv
// Memory-mapped button/switch input port: synchronizers, button debouncer, press counter.
// Optional interrupt output and enable register when XINPUT_PORT_IRQ_EN is defined.
module xinput_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        btn,
    input  logic [7:0]  sw
`ifdef XINPUT_PORT_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic {
        STABLE,
        CHANGING
    } db_state_t;

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic        btn_meta;
    logic        btn_sync;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic        btn_db;
    logic [15:0] count;
    db_state_t   state;
    logic        press_flag;
    logic [7:0]  press_cnt;
    logic        press_evt;
    logic        clr_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    // The first mismatching edge already counts as 1 so btn_db moves on edge DEBOUNCE_CYCLES+2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= STABLE;
            count  <= '0;
            btn_db <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (btn_sync != btn_db) begin
                        state <= CHANGING;
                        count <= 16'd1;
                    end else begin
                        count <= '0;
                    end
                end
                CHANGING: begin
                    if (btn_sync == btn_db) begin
                        state <= STABLE;
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state  <= STABLE;
                        count  <= '0;
                        btn_db <= ~btn_db;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                default: begin
                    state <= STABLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign press_evt = (state == CHANGING) && (btn_sync != btn_db) &&
                       (count == CNT_MAX) && !btn_db;
    assign clr_wr    = sel && we && (addr == 2'd2);

    // A press on the same edge as a clear wins and counts as the first press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_flag <= 1'b0;
            press_cnt  <= '0;
        end else if (press_evt) begin
            press_flag <= 1'b1;
            if (clr_wr)
                press_cnt <= 8'd1;
            else if (press_cnt != 8'hFF)
                press_cnt <= press_cnt + 8'd1;
        end else if (clr_wr) begin
            press_flag <= 1'b0;
            press_cnt  <= '0;
        end
    end

`ifdef XINPUT_PORT_IRQ_EN
    logic irq_en;
    logic unused_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            irq_en <= 1'b0;
        else if (sel && we && (addr == 2'd3))
            irq_en <= data_in[0];
    end

    assign irq         = press_flag & irq_en;
    assign unused_data = ^data_in[31:1];
`else
    logic unused_data;
    assign unused_data = ^data_in;
`endif

    always_comb begin
        data_out = '0;
        if (sel && !we) begin
            case (addr)
                2'd0: data_out = {31'b0, btn_db};
                2'd1: data_out = {24'b0, sw_sync};
                2'd2: data_out = {23'b0, press_flag, press_cnt};
`ifdef XINPUT_PORT_IRQ_EN
                2'd3: data_out = {31'b0, irq_en};
`else
                2'd3: data_out = '0;
`endif
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xinput_port.sv
// Self-checking bench for xinput_port with DEBOUNCE_CYCLES=4 against a sliding-window model.
// Exercises the interrupt path too when XINPUT_PORT_IRQ_EN is defined.
module tb_xinput_port;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        btn = 1'b0;
    logic [7:0]  sw = '0;
`ifdef XINPUT_PORT_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    xinput_port #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .we(we),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .btn(btn),
        .sw(sw)
`ifdef XINPUT_PORT_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Model: btn_db toggles once the last DB synchronized samples all differ from it.
    logic       m_b1 = 1'b0, m_b2 = 1'b0, m_db = 1'b0, m_flag = 1'b0, m_irq_en = 1'b0;
    logic [7:0] m_sw1 = '0, m_sw2 = '0;
    int         m_cnt = 0;
    logic       win[$];

    initial begin : model
        logic s;
        logic rise;
        logic clr;
        bit   all_diff;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_b1 = 0; m_b2 = 0; m_db = 0; m_flag = 0; m_irq_en = 0;
                m_sw1 = '0; m_sw2 = '0; m_cnt = 0;
                win.delete();
            end else begin
                s = m_b2;
                win.push_back(s);
                if (win.size() > DB) void'(win.pop_front());
                all_diff = (win.size() == DB);
                foreach (win[i]) if (win[i] == m_db) all_diff = 0;
                rise = 0;
                if (all_diff) begin
                    rise = !m_db;
                    m_db = !m_db;
                end
                clr = sel && we && (addr == 2'd2);
                if (rise) begin
                    m_flag = 1;
                    m_cnt = clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
                end else if (clr) begin
                    m_flag = 0;
                    m_cnt = 0;
                end
`ifdef XINPUT_PORT_IRQ_EN
                if (sel && we && (addr == 2'd3)) m_irq_en = data_in[0];
`endif
                m_b2 = m_b1; m_b1 = btn;
                m_sw2 = m_sw1; m_sw1 = sw;
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0: return {31'b0, m_db};
            2'd1: return {24'b0, m_sw2};
            2'd2: return {23'b0, m_flag, 8'(m_cnt)};
`ifdef XINPUT_PORT_IRQ_EN
            2'd3: return {31'b0, m_irq_en};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic bus_read(input logic [1:0] a);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
    endtask

    task automatic bus_idle();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            checks++;
            if (data_out !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, data_out, 32'd0);
            end
        end
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_press();
        btn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            bus_read(2'd0);
            checks++;
            if (data_out !== ((e >= DB + 2) ? 32'd1 : 32'd0) || data_out !== exp_read(2'd0)) begin
                errors++;
                $display("FAIL press_latency edge=%0d got=%h exp=%h", e, data_out,
                         (e >= DB + 2) ? 32'd1 : 32'd0);
            end
        end
        bus_read(2'd2);
        checks++;
        if (data_out !== 32'h101) begin
            errors++;
            $display("FAIL press_count got=%h exp=%h", data_out, 32'h101);
        end
        bus_idle();
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        bus_write(2'd2, 32'd0);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            bus_read(2'd0);
            checks++;
            if (data_out !== 32'd0) begin
                errors++;
                $display("FAIL glitch_db cycle=%0d got=%h exp=%h", e, data_out, 32'd0);
            end
        end
        bus_read(2'd2);
        checks++;
        if (data_out !== 32'd0) begin
            errors++;
            $display("FAIL glitch_count got=%h exp=%h", data_out, 32'd0);
        end
        bus_idle();
    endtask

    task automatic test_clear_collision();
        btn = 1'b1;
        repeat (DB + 1) @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = 2'd2; data_in = '0;
        @(negedge clk);
        bus_idle();
        bus_read(2'd2);
        checks++;
        if (data_out !== 32'h101 || data_out !== exp_read(2'd2)) begin
            errors++;
            $display("FAIL clear_collision got=%h exp=%h", data_out, 32'h101);
        end
        bus_idle();
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_saturation();
        bus_write(2'd2, 32'd0);
        for (int p = 0; p < 256; p++) begin
            btn = 1'b1;
            repeat (8) @(negedge clk);
            btn = 1'b0;
            repeat (8) @(negedge clk);
        end
        bus_read(2'd2);
        checks++;
        if (data_out !== 32'h1FF || data_out !== exp_read(2'd2)) begin
            errors++;
            $display("FAIL saturate got=%h exp=%h", data_out, 32'h1FF);
        end
        bus_idle();
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2);
        checks++;
        if (data_out !== 32'd0) begin
            errors++;
            $display("FAIL clear_after_sat got=%h exp=%h", data_out, 32'd0);
        end
        bus_idle();
    endtask

    task automatic test_sw_sel();
        logic [31:0] prev;
        prev = exp_read(2'd1);
        sw = 8'hA5;
        @(negedge clk);
        bus_read(2'd1);
        checks++;
        if (data_out !== prev) begin
            errors++;
            $display("FAIL sw_one_edge got=%h exp=%h", data_out, prev);
        end
        bus_idle();
        @(negedge clk);
        bus_read(2'd1);
        checks++;
        if (data_out !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL sw_two_edges got=%h exp=%h", data_out, 32'h0000_00A5);
        end
        for (int a = 0; a < 4; a++) begin
            for (int w = 0; w < 2; w++) begin
                sel = 1'b0; we = 1'(w); addr = 2'(a);
                #1;
                checks++;
                if (data_out !== 32'd0) begin
                    errors++;
                    $display("FAIL sel_low addr=%0d we=%0d got=%h exp=%h", a, w, data_out, 32'd0);
                end
            end
        end
        bus_idle();
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        sel = 1'b0; we = 1'b1; addr = 2'd3; data_in = 32'd1;
        @(negedge clk);
        bus_idle();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            checks++;
            if (data_out !== exp_read(2'(a))) begin
                errors++;
                $display("FAIL write_ignore addr=%0d got=%h exp=%h", a, data_out, exp_read(2'(a)));
            end
        end
        bus_idle();
    endtask

    task automatic test_random();
        int hold;
        logic [1:0] a;
        hold = $urandom_range(1, 8);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus_idle();
            if (hold == 0) begin
                btn = ~btn;
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            a = 2'($urandom_range(0, 3));
            bus_read(a);
            checks++;
            if (data_out !== exp_read(a)) begin
                errors++;
                $display("FAIL random_read cycle=%0d addr=%0d got=%h exp=%h", c, a, data_out, exp_read(a));
            end
            case ($urandom_range(0, 9))
                0, 1: begin
                    sel = 1'b1; we = 1'b1; addr = 2'($urandom_range(0, 3)); data_in = $urandom;
                end
                2, 3: begin
                    sel = 1'b0; we = 1'($urandom_range(0, 1)); addr = 2'($urandom_range(0, 3));
                    data_in = $urandom;
                end
                default: bus_idle();
            endcase
        end
        @(negedge clk);
        bus_idle();
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_changing();
        btn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            checks++;
            if (data_out !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_read addr=%0d got=%h exp=%h", a, data_out, 32'd0);
            end
        end
`ifdef XINPUT_PORT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_irq got=%b exp=%b", irq, 1'b0);
        end
`endif
        bus_idle();
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(2'd0);
        checks++;
        if (data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_abandon got=%h exp=%h", data_out, 32'd0);
        end
        bus_idle();
    endtask

`ifdef XINPUT_PORT_IRQ_EN
    task automatic test_irq();
        bus_write(2'd2, 32'd0);
        bus_write(2'd3, 32'd1);
        bus_read(2'd3);
        checks++;
        if (data_out !== 32'd1) begin
            errors++;
            $display("FAIL irq_en_read got=%h exp=%h", data_out, 32'd1);
        end
        bus_idle();
        btn = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got=%b exp=%b", irq, 1'b1);
        end
        bus_write(2'd2, 32'd0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%b exp=%b", irq, 1'b0);
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_clear_collision();
        test_sw_sel();
        test_random();
        test_saturation();
`ifdef XINPUT_PORT_IRQ_EN
        test_irq();
`endif
        test_reset_mid_changing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xinput_port.md
XINPUT_PORT -- requirements
Module: xinput_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: stable cycles required before debounced button changes; legal range 2..65535.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset; one clock, asynchronous active-low reset.
REQ-004 Port sel  input  1  bus select from the address decoder; access valid only when high.
REQ-005 Port we  input  1  write enable; high with sel = write, low with sel = read.
REQ-006 Port addr  input  2  register offset within the block.
REQ-007 Port data_in  input  32  write data.
REQ-008 Port data_out  output  32  read data to the decoder read mux.
REQ-009 Port btn  input  1  raw asynchronous push-button.
REQ-010 Port sw  input  8  raw asynchronous slide switches.

Function
REQ-011 btn and sw each SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL have two states: STABLE (sync == btn_db, counter held at 0) and CHANGING (sync != btn_db).
REQ-013 In CHANGING, each edge: counter == DEBOUNCE_CYCLES-1 -> btn_db toggles, counter 0, go STABLE; else counter +1.
REQ-014 In CHANGING, sync returning equal to btn_db SHALL clear the counter and return to STABLE with no btn_db change.
REQ-015 A clean btn level change held stable SHALL reach btn_db on the (DEBOUNCE_CYCLES+2)th rising edge after it is set up at the first synchronizer flop.
REQ-016 A 0->1 transition of btn_db SHALL set sticky flag press_flag and increment 8-bit press_cnt, saturating at 255.
REQ-017 Register map, read: addr 0 = {31'b0, btn_db}; addr 1 = {24'b0, synchronized sw}; addr 2 = {23'b0, press_flag, press_cnt}; addr 3 per REQ-026/027.
REQ-018 data_out SHALL be combinational from addr and register state when sel=1 and we=0, and 32'd0 otherwise.
REQ-019 Write to addr 2 (sel=1, we=1) SHALL clear press_cnt and press_flag at the next edge.
REQ-020 Clear and press edge on the same cycle: the edge wins; result press_cnt=1, press_flag=1.
REQ-021 Writes to addr 0 and addr 1 SHALL be ignored; reads SHALL have no side effects.
REQ-022 sel=0 SHALL inhibit all register writes regardless of we.

Reset
REQ-023 rst low SHALL asynchronously force synchronizer flops, btn_db, counter, press_cnt, press_flag and irq_en to 0 and the state to STABLE.
REQ-024 data_out SHALL be 32'd0 while in reset; irq, when present, SHALL be 0.
REQ-025 Reset asserted during CHANGING SHALL abandon the count; btn_db SHALL not toggle.

Configuration
REQ-026 With macro XINPUT_PORT_IRQ_EN defined: output port irq (1 bit) = press_flag AND irq_en; a write to addr 3 loads irq_en from data_in[0]; a read of addr 3 returns {31'b0, irq_en}.
REQ-027 Without XINPUT_PORT_IRQ_EN: no irq port, no irq_en register, writes to addr 3 ignored, reads return 32'd0.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 btn 0->1 held -> addr 0 reads 1 from the 6th edge on; press_cnt=1, press_flag=1.
REQ-029 btn pulse high for 3 cycles then low -> btn_db stays 0; press_cnt stays 0.
REQ-030 256 clean presses -> press_cnt reads 255 (saturated); write addr 2 -> addr 2 reads 0.
REQ-031 Write addr 2 on the same edge btn_db rises -> addr 2 reads 0x101.
REQ-032 sw=0xA5 -> addr 1 reads 0x000000A5 after 2 edges; sel=0 with any addr -> data_out 0.
REQ-033 IRQ_EN build: write addr 3 = 1, one press -> irq=1; write addr 2 -> irq=0; rst low mid-CHANGING -> all outputs 0.
